// File: rtl/program_sequencer_stack_if.sv
// Decoder <-> sequencer bundle: control strobes and jump field in, fetch address and stack status out.
interface program_sequencer_stack_if #(
   parameter int ADDR_W      = 8,
   parameter int JMP_W       = 4,
   parameter int STACK_DEPTH = 4
);
   localparam int DW = $clog2(STACK_DEPTH + 1);

   logic              sync_reset;
   logic              jmp;
   logic              jmp_nz;
   logic              dont_jmp;
   logic              call;
   logic              ret;
   logic              hold;
   logic [JMP_W-1:0]  jmp_addr;
   logic [ADDR_W-1:0] pm_addr;
   logic [ADDR_W-1:0] pc;
   logic [DW-1:0]     stack_depth;
   logic              stack_ovf;
   logic              stack_unf;

   modport master (
      output sync_reset, jmp, jmp_nz, dont_jmp, call, ret, hold, jmp_addr,
      input  pm_addr, pc, stack_depth, stack_ovf, stack_unf
   );

   modport slave (
      input  sync_reset, jmp, jmp_nz, dont_jmp, call, ret, hold, jmp_addr,
      output pm_addr, pc, stack_depth, stack_ovf, stack_unf
   );
endinterface

// File: rtl/program_sequencer_stack.sv
// Program sequencer: combinational fetch address, registered pc, call/return stack
// with sticky overflow/underflow flags and a fetch stall.
module program_sequencer_stack #(
   parameter int ADDR_W      = 8,
   parameter int JMP_W       = 4,
   parameter int STACK_DEPTH = 4,
   parameter bit COUNT_DOWN  = 1'b1
) (
   input logic                    clk,
   input logic                    reset,
   program_sequencer_stack_if.slave bus
);
   localparam int DW = $clog2(STACK_DEPTH + 1);
   localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [ADDR_W-1:0] START = COUNT_DOWN ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};

   typedef enum logic [2:0] {
      SRC_START,
      SRC_JMP,
      SRC_CALL,
      SRC_RET,
      SRC_HOLD,
      SRC_SEQ
   } src_e;

   logic [ADDR_W-1:0] pc_q;
   logic [DW-1:0]     depth_q;
   logic              ovf_q;
   logic              unf_q;
   logic [ADDR_W-1:0] stk [STACK_DEPTH];

   logic [ADDR_W-1:0] seq;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] top;
   logic [ADDR_W-1:0] pm_addr;
   logic              empty;
   logic              full;
   logic              ret_unf;
   src_e              src;

   assign seq    = COUNT_DOWN ? pc_q - ADDR_W'(1) : pc_q + ADDR_W'(1);
   assign target = ADDR_W'(bus.jmp_addr) << (ADDR_W - JMP_W);
   assign empty  = (depth_q == '0);
   assign full   = (depth_q == DW'(STACK_DEPTH));
   // Only meaningful when not empty; the mux below never selects it otherwise.
   assign top    = stk[IW'(depth_q - DW'(1))];

   always_comb begin
      src = SRC_SEQ;
      if (reset || bus.sync_reset)          src = SRC_START;
      else if (bus.jmp)                     src = SRC_JMP;
      else if (bus.jmp_nz && !bus.dont_jmp) src = SRC_JMP;
      else if (bus.call)                    src = SRC_CALL;
      else if (bus.ret && !empty)           src = SRC_RET;
      else if (bus.hold)                    src = SRC_HOLD;
   end

   // A ret that reaches the stack with nothing on it falls through to hold/seq.
   assign ret_unf = bus.ret && empty && (src == SRC_SEQ || src == SRC_HOLD);

   always_comb begin
      pm_addr = seq;
      case (src)
         SRC_START: pm_addr = START;
         SRC_JMP:   pm_addr = target;
         SRC_CALL:  pm_addr = target;
         SRC_RET:   pm_addr = top;
         SRC_HOLD:  pm_addr = pc_q;
         default:   pm_addr = seq;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= START;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q <= pm_addr;
         if (bus.sync_reset) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
         end else begin
            if (src == SRC_CALL) begin
               if (full) ovf_q <= 1'b1;
               else      depth_q <= depth_q + DW'(1);
            end else if (src == SRC_RET) begin
               depth_q <= depth_q - DW'(1);
            end
            if (ret_unf) unf_q <= 1'b1;
         end
      end
   end

   // Stack storage has no reset; depth alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (src == SRC_CALL && !full) stk[IW'(depth_q)] <= seq;
   end

   assign bus.pm_addr     = pm_addr;
   assign bus.pc          = pc_q;
   assign bus.stack_depth = depth_q;
   assign bus.stack_ovf   = ovf_q;
   assign bus.stack_unf   = unf_q;
endmodule

// File: tb/tb_program_sequencer_stack.sv
// Directed bench for program_sequencer_stack: count-down instance plus a count-up instance for wrap.
module tb_program_sequencer_stack;
   logic clk;
   logic reset;
   int   errors;
   int   checks;

   program_sequencer_stack_if #(.ADDR_W(8), .JMP_W(4), .STACK_DEPTH(4)) bus ();
   program_sequencer_stack_if #(.ADDR_W(8), .JMP_W(4), .STACK_DEPTH(4)) bus_up ();

   program_sequencer_stack #(.ADDR_W(8), .JMP_W(4), .STACK_DEPTH(4), .COUNT_DOWN(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   program_sequencer_stack #(.ADDR_W(8), .JMP_W(4), .STACK_DEPTH(4), .COUNT_DOWN(1'b0)) dut_up (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_up.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.sync_reset = 0; bus.jmp = 0; bus.jmp_nz = 0; bus.dont_jmp = 0;
      bus.call = 0; bus.ret = 0; bus.hold = 0; bus.jmp_addr = '0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      idle();
      bus_up.sync_reset = 0; bus_up.jmp = 0; bus_up.jmp_nz = 0; bus_up.dont_jmp = 0;
      bus_up.call = 0; bus_up.ret = 0; bus_up.hold = 0; bus_up.jmp_addr = '0;

      // Reset held
      #2;
      chk("rst_pm", bus.pm_addr, 8'hFF);
      chk("rst_pc", bus.pc, 8'hFF);
      chk("rst_depth", bus.stack_depth, 0);
      chk("rst_flags", {bus.stack_ovf, bus.stack_unf}, 2'b00);
      chk("rst_up_pm", bus_up.pm_addr, 8'h00);
      step();
      chk("rst_hold_pm", bus.pm_addr, 8'hFF);
      reset = 1'b0;
      #1;
      chk("rel_pc", bus.pc, 8'hFF);
      chk("rel_pm", bus.pm_addr, 8'hFE);
      chk("rel_up_pm", bus_up.pm_addr, 8'h01);
      step(); chk("count_fe", bus.pc, 8'hFE);
      step(); chk("count_fd", bus.pc, 8'hFD);

      // Wrap through zero
      bus.jmp = 1; bus.jmp_addr = 4'h0; #1;
      chk("jmp0_pm", bus.pm_addr, 8'h00);
      step(); idle(); #1;
      chk("pc_zero", bus.pc, 8'h00);
      chk("wrap_pm", bus.pm_addr, 8'hFF);
      step(); chk("wrap_pc", bus.pc, 8'hFF);

      // Jumps
      bus.jmp = 1; bus.jmp_addr = 4'h3; #1;
      chk("jmp_pm", bus.pm_addr, 8'h30);
      step(); idle(); #1;
      chk("jmp_pc", bus.pc, 8'h30);
      bus.jmp_nz = 1; bus.dont_jmp = 1; bus.jmp_addr = 4'h5; #1;
      chk("jnz_not_taken", bus.pm_addr, 8'h2F);
      bus.dont_jmp = 0; #1;
      chk("jnz_taken", bus.pm_addr, 8'h50);
      step(); idle(); #1;
      chk("jnz_pc", bus.pc, 8'h50);

      // Call, hold, return
      bus.call = 1; bus.jmp_addr = 4'h2; #1;
      chk("call_pm", bus.pm_addr, 8'h20);
      step(); idle(); #1;
      chk("call_pc", bus.pc, 8'h20);
      chk("call_depth", bus.stack_depth, 1);
      bus.hold = 1; #1;
      chk("hold_pm", bus.pm_addr, 8'h20);
      step(); step(); idle(); #1;
      chk("hold_pc", bus.pc, 8'h20);
      bus.ret = 1; #1;
      chk("ret_pm", bus.pm_addr, 8'h4F);
      step(); idle(); #1;
      chk("ret_pc", bus.pc, 8'h4F);
      chk("ret_depth", bus.stack_depth, 0);

      // jmp beats call: no push
      bus.jmp = 1; bus.call = 1; bus.jmp_addr = 4'h6; #1;
      chk("jmpcall_pm", bus.pm_addr, 8'h60);
      step(); idle(); #1;
      chk("jmpcall_depth", bus.stack_depth, 0);

      // Five nested calls from 0x60: pushes 5F,0F,1F,2F; fifth overflows
      for (int i = 1; i <= 5; i++) begin
         bus.call = 1; bus.jmp_addr = 4'(i);
         step();
      end
      idle(); #1;
      chk("ovf_pc", bus.pc, 8'h50);
      chk("ovf_depth", bus.stack_depth, 4);
      chk("ovf_flag", bus.stack_ovf, 1);
      chk("ovf_unf_clear", bus.stack_unf, 0);

      bus.ret = 1; #1; chk("pop1", bus.pm_addr, 8'h2F); step();
      #1; chk("pop2", bus.pm_addr, 8'h1F); step();
      #1; chk("pop3", bus.pm_addr, 8'h0F); step();
      #1; chk("pop4", bus.pm_addr, 8'h5F); step();
      #1; chk("pop_depth0", bus.stack_depth, 0);
      chk("unf_pm", bus.pm_addr, 8'h5E);
      step(); idle(); #1;
      chk("unf_pc", bus.pc, 8'h5E);
      chk("unf_flag", bus.stack_unf, 1);
      chk("unf_depth", bus.stack_depth, 0);
      chk("ovf_sticky", bus.stack_ovf, 1);

      // Synchronous restart clears flags
      bus.sync_reset = 1; #1;
      chk("srst_pm", bus.pm_addr, 8'hFF);
      step(); idle(); #1;
      chk("srst_pc", bus.pc, 8'hFF);
      chk("srst_flags", {bus.stack_ovf, bus.stack_unf}, 2'b00);

      // ret right after call returns the just-pushed address
      bus.call = 1; bus.jmp_addr = 4'h7; step();
      idle(); bus.ret = 1; #1;
      chk("call_ret_pm", bus.pm_addr, 8'hFE);
      step(); idle(); #1;
      chk("call_ret_depth", bus.stack_depth, 0);

      // Build depth 3, park pc at 0x42
      for (int i = 1; i <= 3; i++) begin
         bus.call = 1; bus.jmp_addr = 4'(i);
         step();
      end
      idle();
      bus.jmp = 1; bus.jmp_addr = 4'h5; step();
      idle();
      repeat (14) step();
      chk("pre_async_pc", bus.pc, 8'h42);
      chk("pre_async_depth", bus.stack_depth, 3);

      // Asynchronous reset between edges
      #2; reset = 1'b1; #1;
      chk("async_pc", bus.pc, 8'hFF);
      chk("async_depth", bus.stack_depth, 0);
      chk("async_flags", {bus.stack_ovf, bus.stack_unf}, 2'b00);
      chk("async_pm", bus.pm_addr, 8'hFF);
      step();
      reset = 1'b0; #1;
      step(); chk("resume_pc", bus.pc, 8'hFE);

      // Count-up instance wraps 0xFF -> 0x00
      bus_up.jmp = 1; bus_up.jmp_addr = 4'hF; #1;
      chk("up_jmp_pm", bus_up.pm_addr, 8'hF0);
      step(); bus_up.jmp = 0;
      repeat (15) step();
      chk("up_pc_ff", bus_up.pc, 8'hFF);
      chk("up_wrap_pm", bus_up.pm_addr, 8'h00);
      step(); chk("up_wrap_pc", bus_up.pc, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
